// File: rtl/serial_parity_receiver.sv
// Bit-serial parity frame receiver: deserialises DATA_W bits LSB first plus a parity bit,
// delivers each word with its parity-error flag on a single-slot valid/ready port.
module serial_parity_receiver #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin_valid,
  input  logic              sin_bit,
  input  logic              sin_sof,
  output logic [DATA_W-1:0] dout,
  output logic              dout_perr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_cnt
);

  localparam int unsigned BC_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BC_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_d;
  logic              perr_d;
  logic              valid_d;
  logic              frame_err_d;
  logic              overrun_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              load;
  logic              word_err;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      count_q    <= '0;
      dout       <= '0;
      dout_perr  <= 1'b0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      dout       <= dout_d;
      dout_perr  <= perr_d;
      dout_valid <= valid_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
      err_count  <= cnt_d;
    end
  end

  // Next-state, deserialiser, delivery slot and error counter
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    dout_d      = dout;
    perr_d      = dout_perr;
    valid_d     = dout_valid;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    cnt_d       = err_count;
    load        = 1'b0;
    word_err    = 1'b0;

    if (dout_valid && dout_ready) begin
      valid_d = 1'b0;
    end

    if (sin_valid) begin
      if (sin_sof) begin
        // A start-of-frame always restarts; mid-frame it also flags the abort
        frame_err_d = (state_q != S_IDLE);
        shift_d     = DATA_W'(sin_bit);
        count_d     = BC_W'(1);
        state_d     = (DATA_W == 32'd1) ? S_PARITY : S_DATA;
      end else begin
        case (state_q)
          S_DATA: begin
            shift_d = shift_q | (DATA_W'(sin_bit) << count_q);
            count_d = count_q + BC_W'(1);
            if (count_d == BC_W'(DATA_W)) begin
              state_d = S_PARITY;
            end
          end
          S_PARITY: begin
            word_err = (^shift_q) ^ sin_bit ^ PARITY_ODD;
            state_d  = S_IDLE;
            count_d  = '0;
            shift_d  = '0;
            if (!dout_valid || dout_ready) begin
              load = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    if (load) begin
      dout_d  = shift_q;
      perr_d  = word_err;
      valid_d = 1'b1;
    end

    // Clear wins over a same-cycle increment
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (load && word_err && (err_count != '1)) begin
      cnt_d = err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Self-checking bench: even and odd parity instances share one stimulus stream and are
// compared every cycle against a frame-level reference model.
module tb_serial_parity_receiver;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int          CMAX   = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              sin_valid, sin_bit, sin_sof, dout_ready, clr_cnt;
  logic [DATA_W-1:0] dout_e, dout_o;
  logic              perr_e, perr_o, valid_e, valid_o;
  logic              ferr_e, ferr_o, ovr_e, ovr_o;
  logic [CNT_W-1:0]  cnt_e, cnt_o;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          in_frame;
  int          nb;
  int unsigned acc;
  bit          m_valid;
  int unsigned m_dout;
  bit          m_err, m_err_o;
  int          m_cnt_e, m_cnt_o;
  bit          m_ferr, m_ovr;

  serial_parity_receiver #(.DATA_W(DATA_W), .PARITY_ODD(1'b0), .CNT_W(CNT_W)) u_even (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit), .sin_sof(sin_sof),
    .dout(dout_e), .dout_perr(perr_e), .dout_valid(valid_e), .dout_ready(dout_ready),
    .frame_err(ferr_e), .overrun(ovr_e), .err_count(cnt_e), .clr_cnt(clr_cnt)
  );

  serial_parity_receiver #(.DATA_W(DATA_W), .PARITY_ODD(1'b1), .CNT_W(CNT_W)) u_odd (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit), .sin_sof(sin_sof),
    .dout(dout_o), .dout_perr(perr_o), .dout_valid(valid_o), .dout_ready(dout_ready),
    .frame_err(ferr_o), .overrun(ovr_o), .err_count(cnt_o), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    in_frame = 0; nb = 0; acc = 0;
    m_valid = 0; m_dout = 0; m_err = 0; m_err_o = 0;
    m_cnt_e = 0; m_cnt_o = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic check_all();
    chk("dout_valid", 32'(valid_e), 32'(m_valid));
    chk("dout", 32'(dout_e), m_dout);
    chk("dout_perr", 32'(perr_e), 32'(m_err));
    chk("frame_err", 32'(ferr_e), 32'(m_ferr));
    chk("overrun", 32'(ovr_e), 32'(m_ovr));
    chk("err_count", 32'(cnt_e), 32'(m_cnt_e));
    chk("odd_dout_valid", 32'(valid_o), 32'(m_valid));
    chk("odd_dout", 32'(dout_o), m_dout);
    chk("odd_dout_perr", 32'(perr_o), 32'(m_err_o));
    chk("odd_frame_err", 32'(ferr_o), 32'(m_ferr));
    chk("odd_overrun", 32'(ovr_o), 32'(m_ovr));
    chk("odd_err_count", 32'(cnt_o), 32'(m_cnt_o));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic step(input bit v, input bit b, input bit s);
    bit load, e;
    sin_valid = v; sin_bit = b; sin_sof = s;
    load = 0; e = 0; m_ferr = 0; m_ovr = 0;
    if (v && s) begin
      m_ferr = in_frame; in_frame = 1; acc = 32'(b); nb = 1;
    end else if (v && in_frame) begin
      if (nb < int'(DATA_W)) begin
        acc = acc | (32'(b) << nb); nb++;
      end else begin
        e = ((($countones(acc) + int'(b)) % 2) == 1);
        in_frame = 0;
        if (!m_valid || dout_ready) load = 1; else m_ovr = 1;
      end
    end
    if (load) begin
      m_valid = 1; m_dout = acc; m_err = e; m_err_o = !e;
    end else if (m_valid && dout_ready) begin
      m_valid = 0;
    end
    if (clr_cnt) begin
      m_cnt_e = 0; m_cnt_o = 0;
    end else if (load) begin
      if (e && m_cnt_e < CMAX) m_cnt_e++;
      if (!e && m_cnt_o < CMAX) m_cnt_o++;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic send_frame(input int unsigned data, input bit p, input int maxgap,
                            input bit par_rdy, input bit par_clr);
    bit save;
    for (int i = 0; i <= int'(DATA_W); i++) begin
      if (i > 0) repeat ($urandom_range(maxgap, 0)) step(0, 1'($urandom), 1'($urandom));
      if (i == int'(DATA_W)) begin
        save = dout_ready;
        if (par_rdy) dout_ready = 1;
        if (par_clr) clr_cnt = 1;
        step(1, p, 0);
        dout_ready = save; clr_cnt = 0;
      end else begin
        step(1, 1'(data >> i), i == 0);
      end
    end
  endtask

  initial begin
    int unsigned d;
    sin_valid = 0; sin_bit = 0; sin_sof = 0; dout_ready = 1; clr_cnt = 0;
    reset_model();
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;
    @(negedge clk);

    // Directed even/odd parity frames
    send_frame(32'hA5, 0, 0, 0, 0);
    chk("a5_valid", 32'(valid_e), 32'd1);
    chk("a5_dout", 32'(dout_e), 32'hA5);
    chk("a5_perr", 32'(perr_e), 32'd0);
    chk("a5_cnt", 32'(cnt_e), 32'd0);
    step(0, 0, 0);
    chk("a5_slot_clear", 32'(valid_e), 32'd0);
    send_frame(32'hA5, 1, 0, 0, 0);
    chk("a5p1_perr", 32'(perr_e), 32'd1);
    chk("a5p1_cnt", 32'(cnt_e), 32'd1);
    step(0, 0, 0);
    send_frame(32'h07, 0, 0, 0, 0);
    chk("odd07_perr", 32'(perr_o), 32'd0);
    chk("even07_perr", 32'(perr_e), 32'd1);
    step(0, 0, 0);

    // Random frames with random gaps and occasional back-pressure
    for (int i = 0; i < 100; i++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      send_frame($urandom_range(0, 255), 1'($urandom), 5, 0, 0);
    end
    dout_ready = 1;
    step(0, 0, 0); step(0, 0, 0);

    // Abort on data bit 4, then a full frame starting at that sof
    step(1, 1, 1); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
    step(1, 0, 1);
    chk("abort_ferr", 32'(ferr_e), 32'd1);
    d = 32'h3C;
    for (int i = 1; i < int'(DATA_W); i++) begin
      step(1, 1'(d >> i), 0);
      if (i == 1) chk("abort_ferr_once", 32'(ferr_e), 32'd0);
    end
    chk("abort_no_output", 32'(valid_e), 32'd0);
    step(1, 0, 0);
    chk("abort_dout", 32'(dout_e), 32'h3C);
    chk("abort_perr", 32'(perr_e), 32'd0);
    step(0, 0, 0);

    // Overrun with a full slot, then parity beat coinciding with handshake
    dout_ready = 0;
    send_frame(32'h11, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0);
    send_frame(32'h22, 0, 1, 0, 0);
    chk("ovr_pulse", 32'(ovr_e), 32'd1);
    chk("ovr_dout_kept", 32'(dout_e), 32'h11);
    step(0, 0, 0);
    chk("ovr_one_cycle", 32'(ovr_e), 32'd0);
    send_frame(32'h33, 1, 0, 1, 0);
    chk("hs_load_no_ovr", 32'(ovr_e), 32'd0);
    chk("hs_load_dout", 32'(dout_e), 32'h33);
    dout_ready = 1;
    step(0, 0, 0);

    // Counter saturation and clear-vs-increment priority
    for (int i = 0; i < 300; i++) begin
      d = $urandom_range(0, 255);
      send_frame(d, ~(^d[7:0]), 0, 0, 0);
    end
    chk("cnt_saturated", 32'(cnt_e), 32'd255);
    d = 32'h5A;
    send_frame(d, 1, 0, 0, 1);
    chk("clr_with_err", 32'(cnt_e), 32'd0);
    send_frame(d, 1, 0, 0, 0);
    chk("cnt_after_clr", 32'(cnt_e), 32'd1);

    // Asynchronous reset mid-frame with a held output word
    dout_ready = 0;
    step(0, 0, 0);
    step(1, 1, 1); step(1, 0, 0);
    rst_n = 0;
    #1;
    reset_model();
    chk("rst_valid", 32'(valid_e), 32'd0);
    chk("rst_dout", 32'(dout_e), 32'd0);
    chk("rst_perr", 32'(perr_e), 32'd0);
    chk("rst_cnt", 32'(cnt_e), 32'd0);
    @(negedge clk);
    rst_n = 1;
    dout_ready = 1;
    for (int i = 0; i < 12; i++) step(1, 1'($urandom), 0);
    chk("post_rst_ignored", 32'(valid_e), 32'd0);
    send_frame(32'hC3, 0, 2, 0, 0);
    chk("post_rst_dout", 32'(dout_e), 32'hC3);
    step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
